mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 39 +++
 rtl/mem_responder_lane.sv | 39 +++
 rtl/mem_responder.sv | 150 +++++++++++++++
 tb/tb_mem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared encodings and types for the mem_responder slice: access sizes,
// FSM state codes, the captured request record and the request error rule.
package mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_unsigned;
  } mem_req_t;

  // Live FSM state plus wait counter, kept together so one hierarchical
  // reference (u_dut.fsm) shows the whole control state.
  typedef struct packed {
    logic [1:0] state;
    logic [3:0] count;
  } fsm_t;

  function automatic logic req_is_bad(input mem_req_t r, input logic [31:0] depth);
    logic bad;
    bad = 1'b0;
    if (r.size == SZ_ILLEGAL) bad = 1'b1;
    if ((r.size == SZ_HALF) && r.addr[0]) bad = 1'b1;
    if ((r.size == SZ_WORD) && (r.addr[1:0] != 2'b00)) bad = 1'b1;
    if ({2'b00, r.addr[31:2]} >= depth) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_responder_lane.sv
// Combinational byte-lane logic: merges store data into the addressed lanes
// of a word and extracts/extends the addressed lanes for loads.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] new_word,
  output logic [31:0] rdata
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    new_word = old_word;
    rdata    = old_word;
    byte_val = old_word[{offset, 3'b000} +: 8];
    half_val = old_word[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        new_word[{offset, 3'b000} +: 8] = wdata[7:0];
        rdata = {{24{~is_unsigned & byte_val[7]}}, byte_val};
      end
      SZ_HALF: begin
        new_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        rdata = {{16{~is_unsigned & half_val[15]}}, half_val};
      end
      default: begin
        new_word = wdata;
        rdata    = old_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with a valid/ready request and response channel.
// Define MEM_RESPONDER_ERR_EN to reject bad sizes, misalignment and out-of-range addresses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both 1; valid, once raised, holds its payload stable until that edge.

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  fsm_t        fsm;
  mem_req_t    req_q;
  mem_req_t    in_req;
  mem_req_t    acc_req;
  logic        accept;
  logic        req_bad;
  logic        do_access;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr;
  logic [IDX_W-1:0] idx;
  logic [31:0] old_word;
  logic [31:0] new_word;
  logic [31:0] load_data;
  logic [31:0] rsp_data_next;

  assign in_req = '{write: req_write, addr: req_addr, wdata: req_wdata,
                    size: req_size, is_unsigned: req_unsigned};

  assign req_ready = (fsm.state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the accept edge itself,
  // so the live inputs feed the datapath while idle.
  assign acc_req = (fsm.state == ST_IDLE) ? in_req : req_q;

`ifdef MEM_RESPONDER_ERR_EN
  assign req_bad  = req_is_bad(in_req, 32'(DEPTH_WORDS));
  assign acc_size = acc_req.size;
  assign acc_addr = acc_req.addr;
  assign idx      = IDX_W'(acc_addr[31:2]);
`else
  assign req_bad = 1'b0;

  always_comb begin
    acc_size = (acc_req.size == SZ_ILLEGAL) ? SZ_WORD : acc_req.size;
    acc_addr = acc_req.addr;
    case (acc_size)
      SZ_HALF: acc_addr[0]   = 1'b0;
      SZ_WORD: acc_addr[1:0] = 2'b00;
      default: acc_addr      = acc_req.addr;
    endcase
  end

  assign idx = IDX_W'(acc_addr[31:2] % 30'(DEPTH_WORDS));
`endif

  assign do_access = !rst &&
                     ((accept && !req_bad && (WAIT_CYCLES == 0)) ||
                      ((fsm.state == ST_WAIT) && (fsm.count <= 4'd1)));

  assign old_word      = mem[idx];
  assign rsp_data_next = acc_req.write ? 32'h0 : load_data;

  mem_lane_align u_align (
    .size        (acc_size),
    .offset      (acc_addr[1:0]),
    .is_unsigned (acc_req.is_unsigned),
    .wdata       (acc_req.wdata),
    .old_word    (old_word),
    .new_word    (new_word),
    .rdata       (load_data)
  );

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_access && acc_req.write) mem[idx] <= new_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= '{state: ST_IDLE, count: 4'd0};
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (fsm.state)
        ST_IDLE: begin
          if (accept) begin
            req_q <= in_req;
            if (req_bad) begin
              fsm.state <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (WAIT_CYCLES == 0) begin
              fsm.state <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= rsp_data_next;
            end else begin
              fsm.state <= ST_WAIT;
              fsm.count <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          fsm.count <= fsm.count - 4'd1;
          if (fsm.count <= 4'd1) begin
            fsm.state <= ST_RESP;
            fsm.count <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= rsp_data_next;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            fsm.state <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          fsm <= '{state: ST_IDLE, count: 4'd0};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 1 wait state, one with 3.
module tb_mem_responder;

`ifdef MEM_RESPONDER_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_err;
  logic [31:0] rsp_rdata [2];

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input string tag, input int sel, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    req_valid[sel] = 1'b1;
    n = 0;
    while (!req_ready[sel] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_ready", tag), 32'(req_ready[sel]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[sel] = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_size = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_rsp(input int sel, output int lat);
    lat = 1;
    while (lat < 40) begin
      @(negedge clk);
      if (rsp_valid[sel]) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic release_rsp(input int sel);
    rsp_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[sel] = 1'b0;
  endtask

  task automatic txn(input string tag, input int sel, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er);
    int lat;
    int exp_lat;
    exp_q.push_back(exp_rd);
    exp_lat = exp_er ? 1 : ((sel == 0) ? 2 : 4);
    issue(tag, sel, wr, sz, uns, addr, wd);
    wait_rsp(sel, lat);
    check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s_rdata", tag), rsp_rdata[sel], exp_q.pop_front());
    check($sformatf("%s_err", tag), 32'(rsp_err[sel]), 32'(exp_er));
    release_rsp(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b00; req_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata[0], 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd3);

    // word store then load, one wait state
    txn("sw_deadbeef", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("lw_deadbeef", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // byte lanes with sign / zero extension
    txn("sw_zero_10", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    txn("sb_80_11", 0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h80, 32'h0, 1'b0);
    txn("lb_11", 0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
    txn("lbu_11", 0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h00000080, 1'b0);
    txn("lw_10_merged", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h00008000, 1'b0);

    // half lanes and misaligned half
    txn("sw_aaaa_20", 0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA, 32'h0, 1'b0);
    txn("sh_1234_22", 0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 32'h0, 1'b0);
    txn("lw_20_merged", 0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234AAAA, 1'b0);
    txn("lhu_22", 0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h00001234, 1'b0);
    txn("lh_21_misaligned", 0, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0,
        ERR_EN ? 32'h0 : 32'hFFFFAAAA, ERR_EN);

    // out-of-range address
    txn("sw_word0", 0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h13579BDF, 32'h0, 1'b0);
    txn("lw_100_range", 0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0,
        ERR_EN ? 32'h0 : 32'h13579BDF, ERR_EN);

    // illegal size store
    txn("sw_zero_40", 0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    txn("s11_40", 0, 1'b1, 2'b11, 1'b0, 32'h40, 32'h11223344, 32'h0, ERR_EN);
    txn("lw_40_after_s11", 0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0,
        ERR_EN ? 32'h0 : 32'h11223344, 1'b0);

    // response backpressure with a competing store held on the request side
    issue("bp_lw_20", 0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    wait_rsp(0, lat);
    check("bp_lat", 32'(lat), 32'd2);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_valid_%0d", i), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp_rdata_%0d", i), rsp_rdata[0], 32'h1234AAAA);
      check($sformatf("bp_req_ready_%0d", i), 32'(req_ready[0]), 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_release_req_ready", 32'(req_ready[0]), 32'd1);
    check("bp_release_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    txn("lw_20_after_bp", 0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234AAAA, 1'b0);

    // three wait states, reset drops an in-flight store
    txn("w3_sw_prior", 1, 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE0000, 32'h0, 1'b0);
    issue("w3_sw_55", 1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h00000055);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("w3_rst_rsp_valid_async", 32'(rsp_valid[1]), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("w3_rst_rsp_valid_held", 32'(rsp_valid[1]), 32'd0);
    rst = 1'b0;
    #1;
    check("w3_req_ready_after_rst", 32'(req_ready[1]), 32'd1);
    repeat (4) @(negedge clk);
    check("w3_no_late_rsp", 32'(rsp_valid[1]), 32'd0);
    txn("w3_lw_prior", 1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hCAFE0000, 1'b0);
    txn("w1_lw_10_after_rst", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h00008000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
